// File: rtl/maze_mul_pkg.sv
// Shared definitions for the maze-search multiplier sharing logic.
package maze_mul_pkg;

  localparam int MUL_OP_W  = 22;
  localparam int MUL_RES_W = 25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } mul_arb_state_t;

endpackage

// File: rtl/mul_bit.sv
// Shared multiplier: product of two operands truncated to RES_W bits.
// Output is forced to zero when exe is low so an idle multiplier is quiet.
module mul_bit
  import maze_mul_pkg::*;
#(
  parameter int OP_W  = MUL_OP_W,
  parameter int RES_W = MUL_RES_W
) (
  input  logic [OP_W-1:0]  op1,
  input  logic [OP_W-1:0]  op2,
  input  logic             exe,
  output logic [RES_W-1:0] product
);

  // Multiplying in RES_W bits keeps exactly the low RES_W bits of the full product.
  always_comb begin
    product = '0;
    if (exe) product = RES_W'(op1) * RES_W'(op2);
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one mul_bit among NREQ requesters.
//
// Handshake: a request on slot i is transferred on a rising edge where
// req_valid[i] and req_ready[i] are both high; req_ready is one-hot and only
// asserted in IDLE. A response is offered by holding rsp_valid[gnt] high with
// rsp_result stable until the same slot raises rsp_ack; acks from other slots
// are ignored.
module mul_arbiter
  import maze_mul_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int OP_W  = MUL_OP_W,
  parameter int RES_W = MUL_RES_W
) (
  input  logic                 m_clock,
  input  logic                 p_reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OP_W-1:0] req_op1,
  input  logic [NREQ*OP_W-1:0] req_op2,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [RES_W-1:0]     rsp_result,
  input  logic [NREQ-1:0]      rsp_ack,
  output logic                 busy,
  output mul_arb_state_t       dbg_state
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [GW-1:0] LAST_RST = GW'(NREQ - 1);

  mul_arb_state_t  state, state_nxt;
  logic [GW-1:0]   last_grant, gnt_r, pick;
  logic [OP_W-1:0] op1_r, op2_r, op1_sel, op2_sel;
  logic [RES_W-1:0] res_r, mul_p;
  logic            accept, mul_exe, release_gnt;

  // First valid slot found searching upward from last+1, wrapping at NREQ.
  function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                            input logic [GW-1:0]   last);
    logic [GW-1:0] idx;
    logic          found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = GW'((int'(last) + k) % NREQ);
      if (!found && v[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign pick    = rr_pick(req_valid, last_grant);
  assign op1_sel = req_op1[int'(pick)*OP_W +: OP_W];
  assign op2_sel = req_op2[int'(pick)*OP_W +: OP_W];

  mul_bit #(
    .OP_W  (OP_W),
    .RES_W (RES_W)
  ) u_mul_bit (
    .op1     (op1_r),
    .op2     (op2_r),
    .exe     (mul_exe),
    .product (mul_p)
  );

  // Next-state and handshake strobes; req_ready is held low while reset is asserted.
  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    accept      = 1'b0;
    mul_exe     = 1'b0;
    release_gnt = 1'b0;
    case (state)
      IDLE: begin
        if (p_reset && (|req_valid)) begin
          accept          = 1'b1;
          req_ready[pick] = 1'b1;
          state_nxt       = MUL;
        end
      end
      MUL: begin
        mul_exe   = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        if (rsp_ack[gnt_r]) begin
          release_gnt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response outputs are pure decodes of registered state.
  always_comb begin
    rsp_valid = '0;
    if (state == DONE) rsp_valid[gnt_r] = 1'b1;
  end

  assign rsp_result = res_r;
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

  // State register plus the latched grant, operands and product.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state      <= IDLE;
      last_grant <= LAST_RST;
      gnt_r      <= '0;
      op1_r      <= '0;
      op2_r      <= '0;
      res_r      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        gnt_r <= pick;
        op1_r <= op1_sel;
        op2_r <= op2_sel;
      end
      if (mul_exe)     res_r      <= mul_p;
      if (release_gnt) last_grant <= gnt_r;
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed self-checking bench for mul_arbiter (NREQ=4).
module tb_mul_arbiter;
  import maze_mul_pkg::*;

  localparam int NREQ  = 4;
  localparam int OP_W  = 22;
  localparam int RES_W = 25;

  logic                 m_clock;
  logic                 p_reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*OP_W-1:0] req_op1;
  logic [NREQ*OP_W-1:0] req_op2;
  logic [NREQ-1:0]      rsp_valid;
  logic [RES_W-1:0]     rsp_result;
  logic [NREQ-1:0]      rsp_ack;
  logic                 busy;
  mul_arb_state_t       dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [31:0] exp_q[$];

  mul_arbiter #(.NREQ(NREQ), .OP_W(OP_W), .RES_W(RES_W)) dut (
    .m_clock    (m_clock),
    .p_reset    (p_reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_ack    (rsp_ack),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Clock and cycle counter
  initial m_clock = 1'b0;
  always #5 m_clock = ~m_clock;
  always @(posedge m_clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge m_clock);
    #1;
  endtask

  task automatic do_reset();
    p_reset   = 1'b0;
    req_valid = '0;
    req_op1   = '0;
    req_op2   = '0;
    rsp_ack   = '0;
    step();
    step();
    p_reset = 1'b1;
  endtask

  task automatic set_req(input int idx, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    req_op1[idx*OP_W +: OP_W] = a;
    req_op2[idx*OP_W +: OP_W] = b;
    req_valid[idx]            = 1'b1;
  endtask

  // Full op from IDLE with an immediate ack; caller is just after a rising edge.
  task automatic do_op(input string tag, input int idx, input logic [OP_W-1:0] a,
                       input logic [OP_W-1:0] b, input logic [RES_W-1:0] exp);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    set_req(idx, a, b);
    @(negedge m_clock);
    check({tag, "_ready"}, 32'(req_ready), 32'(oh));
    check({tag, "_idle_busy"}, 32'(busy), 0);
    step();
    req_valid[idx] = 1'b0;
    @(negedge m_clock);
    check({tag, "_mul_busy"}, 32'(busy), 1);
    check({tag, "_mul_rspv"}, 32'(rsp_valid), 0);
    step();
    @(negedge m_clock);
    check({tag, "_rspv"}, 32'(rsp_valid), 32'(oh));
    check({tag, "_result"}, 32'(rsp_result), 32'(exp));
    rsp_ack[idx] = 1'b1;
    step();
    rsp_ack = '0;
    @(negedge m_clock);
    check({tag, "_after_busy"}, 32'(busy), 0);
    check({tag, "_after_rspv"}, 32'(rsp_valid), 0);
    step();
  endtask

  initial begin
    int n;
    int gidx;
    int last_cyc;
    p_reset   = 1'b1;
    req_valid = '0;
    req_op1   = '0;
    req_op2   = '0;
    rsp_ack   = '0;
    #2;
    do_reset();

    // Reset state
    @(negedge m_clock);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_rspv", 32'(rsp_valid), 0);
    check("rst_result", 32'(rsp_result), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    step();

    // Single op and products at the boundaries
    do_op("single", 1, 22'd3, 22'd5, 25'd15);
    do_op("trunc", 0, 22'h3FFFFF, 22'h3FFFFF, 25'h1800001);
    do_op("pow2", 2, 22'h200000, 22'd4, 25'h0800000);
    do_op("wrap0", 3, 22'h200000, 22'h200000, 25'h0);
    do_op("mid", 3, 22'd1000, 22'd1000, 25'd1000000);

    // Fairness: all valid, acks always high
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 22'(i + 2), 22'd10);
    rsp_ack = '1;
    exp_q = {0, 1, 2, 3, 0, 1};
    last_cyc = 0;
    for (int g = 0; g < 6; g++) begin
      n = 0;
      @(negedge m_clock);
      while (req_ready == '0 && n < 20) begin
        @(negedge m_clock);
        n++;
      end
      gidx = -1;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) gidx = i;
      check("fair_gnt", 32'(gidx), exp_q.pop_front());
      if (g > 0) check("fair_gap", 32'(cyc - last_cyc), 3);
      last_cyc = cyc;
    end
    req_valid = '0;
    rsp_ack   = '0;

    // Ack stall with wrong-index acks
    do_reset();
    set_req(2, 22'd7, 22'd9);
    step();
    req_valid[2] = 1'b0;
    step();
    @(negedge m_clock);
    check("stall_rspv0", 32'(rsp_valid), 32'h4);
    check("stall_res0", 32'(rsp_result), 63);
    set_req(0, 22'd6, 22'd7);
    rsp_ack = 4'b1011;
    for (int k = 0; k < 5; k++) begin
      step();
      @(negedge m_clock);
      check("stall_rspv", 32'(rsp_valid), 32'h4);
      check("stall_res", 32'(rsp_result), 63);
      check("stall_ready", 32'(req_ready), 0);
    end
    rsp_ack = 4'b0100;
    step();
    rsp_ack = '0;
    @(negedge m_clock);
    check("stall_next_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    step();
    @(negedge m_clock);
    check("stall_next_res", 32'(rsp_result), 42);
    rsp_ack = 4'b0001;
    step();
    rsp_ack = '0;

    // Reset during MUL
    do_reset();
    set_req(1, 22'd3, 22'd5);
    step();
    req_valid[1] = 1'b0;
    set_req(2, 22'd11, 22'd3);
    set_req(0, 22'd6, 22'd7);
    #2;
    p_reset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_ready", 32'(req_ready), 0);
    check("midrst_rspv", 32'(rsp_valid), 0);
    check("midrst_res", 32'(rsp_result), 0);
    step();
    @(negedge m_clock);
    check("midrst_hold_ready", 32'(req_ready), 0);
    step();
    p_reset = 1'b1;
    @(negedge m_clock);
    check("midrst_first", 32'(req_ready), 32'h1);
    step();
    req_valid[0] = 1'b0;
    step();
    @(negedge m_clock);
    check("midrst_rspv2", 32'(rsp_valid), 32'h1);
    check("midrst_res2", 32'(rsp_result), 42);
    rsp_ack = 4'b0001;
    step();
    rsp_ack = '0;
    @(negedge m_clock);
    check("midrst_second", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    step();
    @(negedge m_clock);
    check("midrst_res3", 32'(rsp_result), 33);
    rsp_ack = 4'b0100;
    step();
    rsp_ack = '0;

    // Late arrival while another op is in MUL
    do_reset();
    set_req(0, 22'd2, 22'd3);
    step();
    req_valid[0] = 1'b0;
    set_req(3, 22'd4, 22'd5);
    @(negedge m_clock);
    check("late_mul_ready", 32'(req_ready), 0);
    step();
    @(negedge m_clock);
    check("late_done_ready", 32'(req_ready), 0);
    check("late_res0", 32'(rsp_result), 6);
    step();
    @(negedge m_clock);
    check("late_wait_ready", 32'(req_ready), 0);
    rsp_ack = 4'b0001;
    step();
    rsp_ack = '0;
    @(negedge m_clock);
    check("late_accept", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    step();
    @(negedge m_clock);
    check("late_rspv", 32'(rsp_valid), 32'h8);
    check("late_res", 32'(rsp_result), 20);
    rsp_ack = 4'b1000;
    step();
    rsp_ack = '0;
    @(negedge m_clock);
    check("late_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
